// File: rtl/seq_div_unit.sv
// ============================================================================
// Module  : seq_div_unit
// Brief   : Iterative radix-2 restoring divider, signed/unsigned per op, with
//           valid/ready handshake, flush and divide-by-zero reporting.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_div_unit #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_prep = 3'd1;
  localparam logic [2:0] c_st_calc = 3'd2;
  localparam logic [2:0] c_st_fix  = 3'd3;
  localparam logic [2:0] c_st_done = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             accept;

  logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d;
  logic [WIDTH-1:0] dvs_raw_q, dvs_raw_d;
  logic             sgn_q, sgn_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH:0]   rem_shift, diff;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (reset) state_q <= c_st_idle;
    else       state_q <= state_d;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: if (accept) state_d = c_st_prep;
      c_st_prep: state_d = (zero_q && EARLY_ZERO) ? c_st_done : c_st_calc;
      c_st_calc: if (cnt_q == c_last_step) state_d = c_st_fix;
      c_st_fix:  state_d = c_st_done;
      c_st_done: begin
        if (accept)         state_d = c_st_prep;
        else if (out_ready) state_d = c_st_idle;
      end
      default:   state_d = c_st_idle;
    endcase
    if (flush) state_d = c_st_idle;
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    in_ready  = ~flush & ((state_q == c_st_idle) | ((state_q == c_st_done) & out_ready));
    accept    = in_valid & in_ready;
    out_valid = (state_q == c_st_done);
    busy      = (state_q != c_st_idle);
  end

  // ----------------------------------------------------------------- datapath
  always_comb begin
    dvd_raw_d   = dvd_raw_q;
    dvs_raw_d   = dvs_raw_q;
    sgn_d       = sgn_q;
    zero_d      = zero_q;
    dvs_mag_d   = dvs_mag_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    dvd_neg   = sgn_q & dvd_raw_q[WIDTH-1];
    dvs_neg   = sgn_q & dvs_raw_q[WIDTH-1];
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, dvs_mag_q};

    if (accept) begin
      dvd_raw_d = dividend;
      dvs_raw_d = divisor;
      sgn_d     = in_signed;
      zero_d    = (divisor == '0);
    end

    case (state_q)
      c_st_prep: begin
        quo_d     = dvd_neg ? -dvd_raw_q : dvd_raw_q;
        dvs_mag_d = dvs_neg ? -dvs_raw_q : dvs_raw_q;
        rem_d     = '0;
        cnt_d     = '0;
        q_neg_d   = dvd_neg ^ dvs_neg;
        r_neg_d   = dvd_neg;
      end
      c_st_calc: begin
        // Quotient bits shift in from the right as dividend bits shift out the top.
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase

    // Result registers load only on entry to DONE; a flush never gets here.
    if ((state_d == c_st_done) && (state_q != c_st_done)) begin
      if (zero_q) begin
        quotient_d  = '1;
        remainder_d = dvd_raw_q;
        dbz_d       = 1'b1;
      end else begin
        quotient_d  = q_neg_q ? -quo_q : quo_q;
        remainder_d = r_neg_q ? -rem_q : rem_q;
        dbz_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_raw_q   <= '0;
      dvs_raw_q   <= '0;
      sgn_q       <= 1'b0;
      zero_q      <= 1'b0;
      dvs_mag_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      dvd_raw_q   <= dvd_raw_d;
      dvs_raw_q   <= dvs_raw_d;
      sgn_q       <= sgn_d;
      zero_q      <= zero_d;
      dvs_mag_q   <= dvs_mag_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire
